vec_wb_arbiter: RTL and testbench

Arbitrates the single vector register file write port between two writeback requesters: the vector ALU (req A) and the vector load/store unit (req B). Uses valid/ready handshakes with round-robin priority. Checks LMUL group alignment before a write reaches the register file. Drives the register file write port (wr_en/waddr/wdata/lmul) through one registered stage.

---
 rtl/vec_wb_arbiter.sv | 113 +++++++++++
 tb/tb_vec_wb_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_wb_arbiter.sv
// Round-robin arbiter for the vector register file write port (ALU vs LSU).
// Define VEC_WB_STATS_EN to add saturating grant/drop counters.
module vec_wb_arbiter #(
  parameter int DATA_WIDTH = 4096,
  parameter int VLEN       = 512,
  parameter int NUM_VREGS  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [3:0]            a_lmul,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic [3:0]            b_lmul,
  input  logic                  stall,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wr_lmul,
  output logic                  err_valid,
  output logic                  err_src,
  output logic                  rr_ptr
`ifdef VEC_WB_STATS_EN
  ,
  output logic [15:0]           a_grant_cnt,
  output logic [15:0]           b_grant_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int MAX_LMUL = DATA_WIDTH / VLEN;
  localparam int SW = (ADDR_WIDTH > 4 ? ADDR_WIDTH : 4) + 1;

  logic                  xfer;
  logic                  grant_b;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  logic [3:0]            g_lmul;
  logic                  lmul_ok;
  logic                  align_ok;
  logic                  range_ok;
  logic                  legal;
  logic [SW-1:0]         g_end;

  always_comb begin
    a_ready = !reset && !stall && a_valid && (!b_valid || !rr_ptr);
    b_ready = !reset && !stall && b_valid && (!a_valid || rr_ptr);
  end

  assign xfer    = a_ready || b_ready;
  assign grant_b = b_ready;
  assign g_addr  = grant_b ? b_addr : a_addr;
  assign g_data  = grant_b ? b_data : a_data;
  assign g_lmul  = grant_b ? b_lmul : a_lmul;

  // Group must be a power of two, fit the data bus, be aligned and in range
  assign lmul_ok  = (g_lmul inside {4'd1, 4'd2, 4'd4, 4'd8}) &&
                    (int'(g_lmul) <= MAX_LMUL);
  assign align_ok = (g_addr & ADDR_WIDTH'(g_lmul - 4'd1)) == '0;
  assign g_end    = SW'(g_addr) + SW'(g_lmul);
  assign range_ok = g_end <= SW'(NUM_VREGS);
  assign legal    = lmul_ok && align_ok && range_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en     <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      wr_lmul   <= 4'd1;
      err_valid <= 1'b0;
      err_src   <= 1'b0;
      rr_ptr    <= 1'b0;
    end else begin
      wr_en     <= xfer && legal;
      err_valid <= xfer && !legal;
      if (xfer) begin
        rr_ptr <= !grant_b;
        if (legal) begin
          waddr   <= g_addr;
          wdata   <= g_data;
          wr_lmul <= g_lmul;
        end else begin
          err_src <= grant_b;
        end
      end
    end
  end

`ifdef VEC_WB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (a_ready && a_grant_cnt != 16'hFFFF)
        a_grant_cnt <= a_grant_cnt + 16'd1;
      if (b_ready && b_grant_cnt != 16'hFFFF)
        b_grant_cnt <= b_grant_cnt + 16'd1;
      // Counted when the drop is decided, so it moves with the err_valid pulse
      if (xfer && !legal && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Scoreboard bench for vec_wb_arbiter: directed cases then random traffic.
// Stats counters are checked when built with VEC_WB_STATS_EN.
module tb_vec_wb_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [4:0]    a_addr, b_addr;
  logic [4095:0] a_data, b_data;
  logic [3:0]    a_lmul, b_lmul;
  logic          stall;
  logic          wr_en;
  logic [4:0]    waddr;
  logic [4095:0] wdata;
  logic [3:0]    wr_lmul;
  logic          err_valid, err_src, rr_ptr;
`ifdef VEC_WB_STATS_EN
  logic [15:0]   a_grant_cnt, b_grant_cnt, drop_cnt;
`endif

  vec_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr),
    .a_data(a_data), .a_lmul(a_lmul),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr),
    .b_data(b_data), .b_lmul(b_lmul),
    .stall(stall), .wr_en(wr_en), .waddr(waddr), .wdata(wdata),
    .wr_lmul(wr_lmul), .err_valid(err_valid), .err_src(err_src),
    .rr_ptr(rr_ptr)
`ifdef VEC_WB_STATS_EN
    ,
    .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            err;
    bit            src;
    logic [4:0]    addr;
    logic [4095:0] data;
    logic [3:0]    lmul;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            rr_m = 0;
  logic [4:0]    last_addr = '0;
  logic [4095:0] last_data = '0;
  logic [3:0]    last_lmul = 4'd1;
  int            na_m = 0, nb_m = 0, nd_m = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [4095:0] got,
                          input logic [4095:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got_lo=%0h exp_lo=%0h", nm, got[63:0], exp[63:0]);
    end
  endtask

  function automatic bit is_legal(int addr, int lmul);
    if (!(lmul == 1 || lmul == 2 || lmul == 4 || lmul == 8)) return 0;
    return (addr % lmul == 0) && (addr + lmul <= 32);
  endfunction

  task automatic push(input bit src, input logic [4:0] ad,
                      input logic [4095:0] dt, input logic [3:0] lm);
    exp_t e;
    e.err  = !is_legal(int'(ad), int'(lm));
    e.src  = src;
    e.addr = ad;
    e.data = dt;
    e.lmul = lm;
    q.push_back(e);
    rr_m = src ? 0 : 1;
    if (src) nb_m = (nb_m < 65535) ? nb_m + 1 : nb_m;
    else     na_m = (na_m < 65535) ? na_m + 1 : na_m;
    if (e.err) nd_m = (nd_m < 65535) ? nd_m + 1 : nd_m;
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge
  task automatic tick();
    bit ea, eb;
    #1;
    ea = !stall && a_valid && (!b_valid || rr_m == 0);
    eb = !stall && b_valid && (!a_valid || rr_m == 1);
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    @(posedge clk);
    if (ea) push(1'b0, a_addr, a_data, a_lmul);
    if (eb) push(1'b1, b_addr, b_data, b_lmul);
    @(negedge clk);
    if (ea) a_valid = 1'b0;
    if (eb) b_valid = 1'b0;
  endtask

  task automatic drain();
    stall = 1'b0;
    for (int i = 0; i < 4 && (a_valid || b_valid); i++) tick();
    chk("drain_idle", {a_valid, b_valid}, 2'b00);
  endtask

  task automatic mon();
    exp_t e;
    if (wr_en || err_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {wr_en, err_valid}, 2'b00);
      end else begin
        e = q.pop_front();
        chk("wr_en", wr_en, !e.err);
        chk("err_valid", err_valid, e.err);
        if (e.err) begin
          chk("err_src", err_src, e.src);
        end else begin
          last_addr = e.addr;
          last_data = e.data;
          last_lmul = e.lmul;
        end
      end
    end else if (q.size() != 0) begin
      e = q.pop_front();
      chk("missing_out", {wr_en, err_valid}, {!e.err, e.err});
    end
    chk("waddr", waddr, last_addr);
    chk("wr_lmul", wr_lmul, last_lmul);
    chk_data("wdata", wdata, last_data);
    chk("rr_ptr", rr_ptr, rr_m[0]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) mon();
    end
  end

  function automatic logic [4095:0] rnd_data();
    logic [4095:0] d;
    for (int i = 0; i < 128; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic rnd_req(output logic [4:0] ad, output logic [3:0] lm);
    int pick;
    pick = $urandom_range(0, 9);
    if (pick < 8) begin
      lm = 4'd1 << $urandom_range(0, 3);
      ad = 5'($urandom_range(0, 31));
      if (pick < 6) ad = ad & ~5'(lm - 4'd1);
    end else begin
      lm = 4'($urandom_range(0, 15));
      ad = 5'($urandom_range(0, 31));
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = '0; b_addr = '0; a_lmul = 4'd1; b_lmul = 4'd1;
    a_data = '0; b_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_waddr", waddr, 5'd0);
    chk_data("rst_wdata", wdata, '0);
    chk("rst_wr_lmul", wr_lmul, 4'd1);
    chk("rst_err", {err_valid, err_src}, 2'b00);
    chk("rst_rr", rr_ptr, 1'b0);
    chk("rst_ready", {a_ready, b_ready}, 2'b00);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;

    // single A write
    a_valid = 1'b1; a_addr = 5'd4; a_lmul = 4'd4;
    a_data = '0; a_data[63:0] = 64'hDEADBEEF;
    tick();

    // contention
    a_addr = 5'd0;  a_lmul = 4'd8; a_data = rnd_data();
    b_addr = 5'd16; b_lmul = 4'd8; b_data = rnd_data();
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; b_valid = 1'b1;
      tick();
    end
    drain();

    // illegal B requests
    b_valid = 1'b1; b_addr = 5'd3;  b_lmul = 4'd2; tick();
    b_valid = 1'b1; b_addr = 5'd28; b_lmul = 4'd8; tick();
    b_valid = 1'b1; b_addr = 5'd6;  b_lmul = 4'd3; tick();

    // stall with both valid
    a_valid = 1'b1; a_addr = 5'd2; a_lmul = 4'd2; a_data = rnd_data();
    b_valid = 1'b1; b_addr = 5'd8; b_lmul = 4'd4; b_data = rnd_data();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    tick();
    drain();

    // async reset while a write is being presented
    a_valid = 1'b1; a_addr = 5'd8; a_lmul = 4'd2; a_data = rnd_data();
    tick();
    b_valid = 1'b1; b_addr = 5'd12; b_lmul = 4'd4; b_data = rnd_data();
    #2;
    chk("pre_rst_wr_en", wr_en, 1'b1);
    reset = 1'b1;
    q.delete();
    rr_m = 0; na_m = 0; nb_m = 0; nd_m = 0;
    last_addr = '0; last_data = '0; last_lmul = 4'd1;
    #1;
    chk("arst_wr_en", wr_en, 1'b0);
    chk("arst_err", err_valid, 1'b0);
    chk("arst_rr", rr_ptr, 1'b0);
    chk("arst_b_ready", b_ready, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (!a_valid && $urandom_range(0, 2) != 0) begin
        a_valid = 1'b1; rnd_req(a_addr, a_lmul); a_data = rnd_data();
      end
      if (!b_valid && $urandom_range(0, 2) != 0) begin
        b_valid = 1'b1; rnd_req(b_addr, b_lmul); b_data = rnd_data();
      end
      stall = ($urandom_range(0, 4) == 0);
      tick();
    end
    drain();

`ifdef VEC_WB_STATS_EN
    chk("a_grant_cnt", a_grant_cnt, 64'(na_m));
    chk("b_grant_cnt", b_grant_cnt, 64'(nb_m));
    chk("drop_cnt", drop_cnt, 64'(nd_m));
    a_addr = 5'd0; a_lmul = 4'd1;
    for (int n = 0; n < 65540; n++) begin
      a_valid = 1'b1;
      tick();
    end
    chk("a_grant_sat", a_grant_cnt, 64'(na_m));
    chk("a_grant_ffff", a_grant_cnt, 64'hFFFF);
`endif

    repeat (2) tick();
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
